maze_store: RTL

Bit-map memory for the maze wall-follower. Holds a 64x64 wall map loaded row-by-row from the host side and a parallel 64x64 visited map. It services the solver's `row`/`col`/`maze_oe`/`maze_we` port, returning `maze_in` with one cycle of latency. After a run it streams the visited map back out for checking.

---
 rtl/maze_store.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/maze_store.sv
`default_nettype none
// ============================================================================
// Module   : maze_store
// Brief    : 64x64 wall map (host-loaded) plus visited map for the maze
//            wall-follower; optional visited-map dump via MAZE_STORE_DUMP_EN.
// Revision : 1.0
// ============================================================================
module maze_store (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [63:0] load_data,
    output logic        load_ready,
    output logic        load_done,
    input  logic [5:0]  row,
    input  logic [5:0]  col,
    input  logic        maze_oe,
    input  logic        maze_we,
    output logic        maze_in,
    output logic [12:0] visit_count,
    input  logic        dump_req,
    output logic        dump_valid,
    output logic [5:0]  dump_row,
    output logic [63:0] dump_data
);

    localparam int          DIM         = 64;
    localparam logic [12:0] c_VISIT_MAX = 13'd4096;

    localparam logic [1:0]  c_ST_LOAD   = 2'd0;
    localparam logic [1:0]  c_ST_RUN    = 2'd1;
`ifdef MAZE_STORE_DUMP_EN
    localparam logic [1:0]  c_ST_DUMP   = 2'd2;
`endif

    logic [1:0]     r_state;
    logic [1:0]     w_state_next;
    logic [5:0]     r_load_ptr;
    logic [DIM-1:0] r_wall    [DIM];
    logic [DIM-1:0] r_visited [DIM];
    logic           r_maze_in;
    logic [12:0]    r_visit_count;
    logic           w_load_fire;
    logic           w_live;

`ifdef MAZE_STORE_DUMP_EN
    logic [5:0]     r_dump_cnt;
    logic           r_dump_valid;
    logic [5:0]     r_dump_row;
    logic [DIM-1:0] r_dump_data;
`endif

    assign load_ready  = (r_state == c_ST_LOAD);
    assign load_done   = (r_state != c_ST_LOAD);
    assign w_load_fire = load_valid && load_ready;
    assign w_live      = (r_state != c_ST_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_LOAD: begin
                if (w_load_fire && (r_load_ptr == 6'd63)) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
`ifdef MAZE_STORE_DUMP_EN
                if (dump_req) begin
                    w_state_next = c_ST_DUMP;
                end
`endif
            end
`ifdef MAZE_STORE_DUMP_EN
            c_ST_DUMP: begin
                if (r_dump_cnt == 6'd63) begin
                    w_state_next = c_ST_RUN;
                end
            end
`endif
            default: w_state_next = c_ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_ptr <= 6'd0;
        end else if (w_load_fire) begin
            r_load_ptr <= r_load_ptr + 6'd1;
        end
    end

    // Wall contents survive reset; a fresh load always overwrites every row.
    always_ff @(posedge clk) begin
        if (w_load_fire && !rst) begin
            r_wall[r_load_ptr] <= load_data;
        end
    end

    // During LOAD the solver sees solid walls everywhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_maze_in <= 1'b0;
        end else if (!w_live) begin
            r_maze_in <= 1'b1;
        end else if (maze_oe) begin
            r_maze_in <= r_wall[row][col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) begin
                r_visited[i] <= '0;
            end
            r_visit_count <= 13'd0;
        end else if (w_live && maze_we && !r_visited[row][col]) begin
            r_visited[row][col] <= 1'b1;
            if (r_visit_count != c_VISIT_MAX) begin
                r_visit_count <= r_visit_count + 13'd1;
            end
        end
    end

    assign maze_in     = r_maze_in;
    assign visit_count = r_visit_count;

`ifdef MAZE_STORE_DUMP_EN
    // Dump word reflects the visited row before any same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dump_cnt   <= 6'd0;
            r_dump_valid <= 1'b0;
            r_dump_row   <= 6'd0;
            r_dump_data  <= '0;
        end else if (r_state == c_ST_DUMP) begin
            r_dump_valid <= 1'b1;
            r_dump_row   <= r_dump_cnt;
            r_dump_data  <= r_visited[r_dump_cnt];
            r_dump_cnt   <= r_dump_cnt + 6'd1;
        end else begin
            r_dump_valid <= 1'b0;
            r_dump_cnt   <= 6'd0;
        end
    end

    assign dump_valid = r_dump_valid;
    assign dump_row   = r_dump_row;
    assign dump_data  = r_dump_data;
`else
    logic w_unused_dump;
    assign w_unused_dump = dump_req;
    assign dump_valid    = 1'b0;
    assign dump_row      = 6'd0;
    assign dump_data     = 64'd0;
`endif

endmodule
`default_nettype wire
